// File: rtl/twiddle_sequencer_pkg.sv
// Shared constants and helpers for the twiddle sequencer.
//   N / LOG2N   : FFT size (32-point) and its log2.
//   TW_ENTRIES  : twiddle ROM depth (W32^0 .. W32^15).
//   cos_q30     : cos(2*pi*j/32) for j = 0..8 in Q30. This is the only angle table;
//                 every other twiddle is derived from it by quadrant symmetry, and the
//                 scale to the coefficient width happens at elaboration in round_scale.
package twiddle_sequencer_pkg;

    localparam int N          = 32;
    localparam int LOG2N      = 5;
    localparam int TW_ENTRIES = 16;
    localparam int ANGLE_FRAC = 30;

    typedef logic [3:0] tw_addr_t;

    // First quadrant of cos(2*pi*j/32), Q30, j = 0..8.
    function automatic longint cos_q30(input int j);
        case (j)
            0:       return 64'sd1073741824;
            1:       return 64'sd1053110176;
            2:       return 64'sd992008094;
            3:       return 64'sd892783698;
            4:       return 64'sd759250125;
            5:       return 64'sd596538995;
            6:       return 64'sd410903207;
            7:       return 64'sd209476638;
            default: return 64'sd0;
        endcase
    endfunction

    // cos(2*pi*k/32), k = 0..15 (second quadrant mirrors the first with sign flip).
    function automatic longint cos_k_q30(input int k);
        return (k <= 8) ? cos_q30(k) : -cos_q30(16 - k);
    endfunction

    // sin(2*pi*k/32), k = 0..15 (non-negative over the half circle).
    function automatic longint sin_k_q30(input int k);
        return (k <= 8) ? cos_q30(8 - k) : cos_q30(k - 8);
    endfunction

    // Rescale a Q30 value to 2^scale_bits, rounding half away from zero.
    function automatic longint round_scale(input longint v, input int scale_bits);
        longint mag;
        mag = (v < 0) ? -v : v;
        mag = (mag * (64'sd1 <<< scale_bits) + (64'sd1 <<< (ANGLE_FRAC - 1))) >>> ANGLE_FRAC;
        return (v < 0) ? -mag : mag;
    endfunction

endpackage

// File: rtl/twiddle_sequencer_rom.sv
// twiddle_rom: 16-entry synchronous-read twiddle ROM.
//   clk, rst : clock, synchronous active-high reset (clears the output register).
//   en       : read enable; output register holds its value when low.
//   addr     : twiddle index k (W32^k).
//   re, im   : round(cos(2*pi*k/32)*2^(WIDTH-3)), round(-sin(2*pi*k/32)*2^(WIDTH-3)).
module twiddle_rom
    import twiddle_sequencer_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  tw_addr_t                addr,
    output logic signed [WIDTH-2:0] re,
    output logic signed [WIDTH-2:0] im
);

    localparam int TW_W       = WIDTH - 1;
    localparam int SCALE_BITS = WIDTH - 3;

    logic [2*TW_W-1:0] table_q [TW_ENTRIES];

    // Contents are fixed at elaboration from WIDTH.
    for (genvar g = 0; g < TW_ENTRIES; g++) begin : g_entry
        localparam longint RE_V = round_scale(cos_k_q30(g), SCALE_BITS);
        localparam longint IM_V = round_scale(-sin_k_q30(g), SCALE_BITS);
        assign table_q[g] = {TW_W'(RE_V), TW_W'(IM_V)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            re <= '0;
            im <= '0;
        end else if (en) begin
            {re, im} <= table_q[addr];
        end
    end

endmodule

// File: rtl/twiddle_sequencer.sv
// twiddle_sequencer: feeds the complex multiplier between two radix-2 DIF MDC stages.
// Tracks the position n of each lower-branch sample within its block, maps it to the
// twiddle index k = n << (STAGE-1), and presents data, coefficients and bypass select
// aligned, exactly 2 cycles after the input.
//   clk, rst           : clock, synchronous active-high reset.
//   in_valid, in_sof   : sample strobe and first-of-frame marker (qualified by in_valid).
//   in_re, in_im       : sample.
//   out_valid, out_sof : aligned strobe / frame marker.
//   x0_re, x0_im       : delayed sample.
//   rom_re, rom_im     : twiddle W32^k.
//   mul_mode           : 1 when k==0 (multiplier bypass) or when no valid output.
module twiddle_sequencer
    import twiddle_sequencer_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int STAGE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    out_valid,
    output logic                    out_sof,
    output logic signed [WIDTH-1:0] x0_re,
    output logic signed [WIDTH-1:0] x0_im,
    output logic signed [WIDTH-2:0] rom_re,
    output logic signed [WIDTH-2:0] rom_im,
    output logic                    mul_mode
);

    localparam int L  = N >> STAGE;
    localparam int NW = LOG2N - STAGE;

    logic [NW-1:0] n, n_use, n_next;
    tw_addr_t      k_now;

    logic [2:1]              vld_pipe;
    logic [2:1]              sof_pipe;
    logic signed [WIDTH-1:0] s1_re, s1_im;
    tw_addr_t                s1_k;

    // A qualified sof restarts the block on this very sample.
    always_comb begin
        n_use  = in_sof ? '0 : n;
        n_next = (n_use == NW'(L - 1)) ? '0 : n_use + NW'(1);
        k_now  = tw_addr_t'(n_use) << (STAGE - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n        <= '0;
            vld_pipe <= '0;
            sof_pipe <= '0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_k     <= '0;
            x0_re    <= '0;
            x0_im    <= '0;
            mul_mode <= 1'b1;
        end else begin
            // Stage 1: capture sample and its twiddle index.
            vld_pipe[1] <= in_valid;
            sof_pipe[1] <= in_valid & in_sof;
            if (in_valid) begin
                n     <= n_next;
                s1_re <= in_re;
                s1_im <= in_im;
                s1_k  <= k_now;
            end
            // Stage 2: aligned with the ROM output register.
            vld_pipe[2] <= vld_pipe[1];
            sof_pipe[2] <= sof_pipe[1];
            if (vld_pipe[1]) begin
                x0_re    <= s1_re;
                x0_im    <= s1_im;
                mul_mode <= (s1_k == '0);
            end else begin
                mul_mode <= 1'b1;
            end
        end
    end

    twiddle_rom #(.WIDTH(WIDTH)) u_rom (
        .clk  (clk),
        .rst  (rst),
        .en   (vld_pipe[1]),
        .addr (s1_k),
        .re   (rom_re),
        .im   (rom_im)
    );

    assign out_valid = vld_pipe[2];
    assign out_sof   = sof_pipe[2];

endmodule
